// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization sequencer.
// Walks WAIT -> PRE -> ARF x ARF_NUM -> MRS -> [EMRS] -> DONE, driving one
// command per step and NOP in between, then holds Init_done until a
// software re-initialization request restarts the sequence at PRE.
module sdram_init_seq #(
   parameter int                ADDR_W        = 12,
   parameter int                BA_W          = 2,
   parameter int                T_POWERUP     = 10000,
   parameter int                T_RP          = 2,
   parameter int                T_RFC         = 7,
   parameter int                T_MRD         = 2,
   parameter int                ARF_NUM       = 2,
   parameter logic [2:0]        CAS_LAT       = 3'd3,
   parameter logic              BURST_TYPE    = 1'b0,
   parameter logic [2:0]        BURST_LEN     = 3'b111,
   parameter logic              WR_BURST_MODE = 1'b0,
   parameter logic              EMRS_EN       = 1'b0,
   parameter logic [ADDR_W-1:0] EMRS_VAL      = '0
) (
   input  logic              Sys_clk,
   input  logic              Rst,
   input  logic              Init_req,
   output logic [3:0]        Command_init,
   output logic [ADDR_W-1:0] Init_a_addr,
   output logic [BA_W-1:0]   Init_bank_addr,
   output logic              Init_busy,
   output logic              Init_done
);

   // One shared delay counter sized for the longest interval in the sequence.
   localparam int T_MAX_A = (T_POWERUP > T_RFC) ? T_POWERUP : T_RFC;
   localparam int T_MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int CNT_W   = $clog2(T_MAX + 1);
   localparam int REF_W   = $clog2(ARF_NUM + 1);

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_ARF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   // A10 high selects all banks for PRECHARGE.
   localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(11'h400);
   localparam logic [ADDR_W-1:0] MRS_ADDR =
      ADDR_W'({WR_BURST_MODE, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN});
   localparam logic [BA_W-1:0]   EMRS_BA  = BA_W'(2'b10);

   // Counter value on the edge that ends each interval.
   localparam logic [CNT_W-1:0] CNT_PWR = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0] CNT_RP  = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] CNT_RFC = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] CNT_MRD = CNT_W'(T_MRD - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(ARF_NUM);

   // State names the last command issued; the counter times the gap after it.
   typedef enum logic [2:0] {
      S_WAIT,
      S_PRE,
      S_ARF,
      S_MRS,
      S_EMRS,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [REF_W-1:0]  r_ref;
   logic [3:0]        r_cmd;
   logic [ADDR_W-1:0] r_addr;
   logic [BA_W-1:0]   r_ba;
   logic              r_busy;
   logic              r_done;

   // Sequencer FSM: issues each command for one cycle, NOP otherwise.
   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         r_state <= S_WAIT;
         r_cnt   <= '0;
         r_ref   <= '0;
         r_cmd   <= CMD_NOP;
         r_addr  <= '0;
         r_ba    <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_cmd  <= CMD_NOP;
         r_addr <= '0;
         r_ba   <= '0;
         r_cnt  <= r_cnt + 1'b1;
         case (r_state)
            S_WAIT: begin
               if (r_cnt == CNT_PWR) begin
                  r_state <= S_PRE;
                  r_cmd   <= CMD_PRE;
                  r_addr  <= PRE_ADDR;
                  r_cnt   <= '0;
                  r_ref   <= '0;
               end
            end
            S_PRE: begin
               if (r_cnt == CNT_RP) begin
                  r_state <= S_ARF;
                  r_cmd   <= CMD_ARF;
                  r_cnt   <= '0;
                  r_ref   <= REF_W'(1);
               end
            end
            S_ARF: begin
               if (r_cnt == CNT_RFC) begin
                  r_cnt <= '0;
                  if (r_ref == REF_LAST) begin
                     r_state <= S_MRS;
                     r_cmd   <= CMD_MRS;
                     r_addr  <= MRS_ADDR;
                  end else begin
                     r_cmd <= CMD_ARF;
                     r_ref <= r_ref + 1'b1;
                  end
               end
            end
            S_MRS: begin
               if (r_cnt == CNT_MRD) begin
                  r_cnt <= '0;
                  if (EMRS_EN) begin
                     r_state <= S_EMRS;
                     r_cmd   <= CMD_MRS;
                     r_addr  <= EMRS_VAL;
                     r_ba    <= EMRS_BA;
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_EMRS: begin
               if (r_cnt == CNT_MRD) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               // Counter parked so it never wraps while idle.
               r_cnt <= '0;
               if (Init_req) begin
                  // Re-init skips the power-up wait and issues PRE right away.
                  r_state <= S_PRE;
                  r_cmd   <= CMD_PRE;
                  r_addr  <= PRE_ADDR;
                  r_ref   <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_WAIT;
               r_cnt   <= '0;
               r_ref   <= '0;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign Command_init   = r_cmd;
   assign Init_a_addr    = r_addr;
   assign Init_bank_addr = r_ba;
   assign Init_busy      = r_busy;
   assign Init_done      = r_done;

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Parametrised SDRAM power-up initialization sequencer; next generation of the fixed-count init block.
- Drives the SDRAM command bus until the mode register is loaded, then hands over to the arbiter/refresh/read/write logic via a level `Init_done`.
- New relative to the previous block:
  - configurable address/bank width and timing;
  - configurable number of auto-refresh cycles;
  - optional extended mode register (EMRS) load;
  - level-held done flag;
  - software re-initialization request.

Parameters:
- ADDR_W, 12, SDRAM address bus width (>=11; A10 = all-bank precharge bit).
- BA_W, 2, bank address width.
- T_POWERUP, 10000, NOP cycles after reset before PRECHARGE (100 us at 100 MHz).
- T_RP, 2, cycles from PRECHARGE to next command (>=1).
- T_RFC, 7, cycles from AUTO REFRESH to next command (>=1).
- T_MRD, 2, cycles from MRS/EMRS to next command or done (>=1).
- ARF_NUM, 2, number of AUTO REFRESH commands (1..16).
- CAS_LAT, 3, 3-bit CAS latency field (A6..A4).
- BURST_TYPE, 0, 1-bit burst type (A3): 0 sequential, 1 interleave.
- BURST_LEN, 3'b111, 3-bit burst length field (A2..A0); 3'b111 = full page.
- WR_BURST_MODE, 0, A9: 0 burst write, 1 single write.
- EMRS_EN, 0, 1 = issue EMRS after MRS.
- EMRS_VAL, 0, ADDR_W-bit value driven on the address bus during EMRS; BA = 2'b10.

Ports:
- Sys_clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Init_req  in  1  re-initialization request; sampled only while Init_done=1.
- Command_init  out  4  {CS_N,RAS_N,CAS_N,WE_N}: NOP=0111, PRE=0010, ARF=0001, MRS/EMRS=0000.
- Init_a_addr  out  ADDR_W  SDRAM address during init.
- Init_bank_addr  out  BA_W  SDRAM bank address during init.
- Init_busy  out  1  high while a sequence is in progress.
- Init_done  out  1  level; high when the SDRAM is initialized.

Behaviour:
- All outputs are registered.
- Reset values: Command_init=NOP, Init_a_addr=0, Init_bank_addr=0, Init_done=0, Init_busy=1. State=WAIT, counter=0, refresh count=0.
- Reset mid-sequence aborts immediately. The sequence restarts from WAIT, including the full T_POWERUP wait.
- Cycle numbering: edge 1 is the first rising edge with Rst=0. Each command is presented for exactly one cycle; all other cycles drive NOP with addr=0 and ba=0.
- FSM states: WAIT -> PRE -> ARF (repeated ARF_NUM times) -> MRS -> [EMRS if EMRS_EN] -> DONE.
- WAIT: PRE is output at edge T_POWERUP.
- PRE: Init_a_addr[10]=1 (all banks), all other address bits 0. The first ARF follows T_RP cycles after PRE.
- ARF: each ARF is followed T_RFC cycles later by the next ARF, or by MRS after the ARF_NUM-th.
- MRS: Init_bank_addr=0. Init_a_addr = {zeros above A9, WR_BURST_MODE, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN}.
- EMRS (only if EMRS_EN=1): issued T_MRD cycles after MRS, with Init_bank_addr=2'b10 and Init_a_addr=EMRS_VAL.
- DONE is entered T_MRD cycles after the last mode command. In DONE: Init_done=1 and Init_busy=0, held indefinitely; Command_init=NOP.
- Re-initialization:
  - Init_req=1 while in DONE: next edge sets Init_done=0, Init_busy=1, state=PRE.
  - PRE is output at that same edge; the power-up wait is skipped.
  - Init_req while Init_busy=1 is ignored; no queuing.
- Single delay counter, width clog2(max(T_POWERUP,T_RFC,T_RP,T_MRD)+1). It reloads on every command and never wraps during a sequence.
- The refresh counter is cleared on entering PRE.

Test Plan:
- Defaults except T_POWERUP=20 -> PRE at edge 20 with addr=0x400; ARF at 22 and 29; MRS at 36 with addr=0x037, ba=0; Init_done rises at edge 38 and Init_busy falls at edge 38; NOP on every other cycle.
- ARF_NUM=4, T_RFC=3, T_POWERUP=20 -> ARF at edges 22, 25, 28, 31; MRS at 34; Init_done at 36.
- EMRS_EN=1, EMRS_VAL=12'h020, T_POWERUP=20 -> MRS at 36; EMRS at 38 with ba=2'b10, addr=0x020; Init_done at 40.
- After done, pulse Init_req at edge N -> at edge N: Init_done=0, Init_busy=1, PRE; sequence repeats with the same relative timing; a second Init_req pulse during busy has no effect.
- Assert Rst at edge 30 (mid-ARF spacing), release -> all outputs return to reset values; PRE reappears 20 edges after release.
- CAS_LAT=2, BURST_LEN=3'b011, BURST_TYPE=1, WR_BURST_MODE=1 -> MRS address = 0x22B.
